// File: rtl/plab4_net_ring_ter_eject_if.sv
// Bundle of the terminal-ejection handshake signals.
//   in_val/in_rdy/in_msg/in_domain : terminal message from the router
//   out_val_dX/out_rdy_dX/out_msg_dX: per-domain consumer ports (X = 0, 1)
//   misroute_cnt                    : saturating misroute counter
// Modports: master = router/consumer side, slave = ejection stage.
interface plab4_net_ring_ter_eject_if #(
  parameter int unsigned p_msg_nbits = 44
);
  logic                   in_val;
  logic                   in_rdy;
  logic [p_msg_nbits-1:0] in_msg;
  logic                   in_domain;
  logic                   out_val_d0;
  logic                   out_rdy_d0;
  logic [p_msg_nbits-1:0] out_msg_d0;
  logic                   out_val_d1;
  logic                   out_rdy_d1;
  logic [p_msg_nbits-1:0] out_msg_d1;
  logic [7:0]             misroute_cnt;

  modport master (
    output in_val, in_msg, in_domain, out_rdy_d0, out_rdy_d1,
    input  in_rdy, out_val_d0, out_msg_d0, out_val_d1, out_msg_d1, misroute_cnt
  );

  modport slave (
    input  in_val, in_msg, in_domain, out_rdy_d0, out_rdy_d1,
    output in_rdy, out_val_d0, out_msg_d0, out_val_d1, out_msg_d1, misroute_cnt
  );
endinterface

// File: rtl/plab4_net_ring_ter_eject.sv
// Terminal ejection stage: steers each accepted ring message into one of two
// independent per-domain FIFOs so one domain's backpressure never stalls the
// other. Counts accepted messages whose dest field differs from p_router_id.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of plab4_net_ring_ter_eject_if (message in,
//                two per-domain consumer ports, misroute_cnt)
// Optional feature: define PLAB4_NET_TER_EJECT_BYPASS_EN for a zero-latency
// path from in_msg to out_msg_dX when QX is empty and its consumer is ready.
module plab4_net_ring_ter_eject #(
  parameter int unsigned p_payload_nbits = 32,
  parameter int unsigned p_opaque_nbits  = 3,
  parameter int unsigned p_srcdest_nbits = 3,
  parameter int unsigned p_router_id     = 0,
  parameter int unsigned p_num_entries   = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  plab4_net_ring_ter_eject_if.slave   bus
);

  localparam int unsigned m  = p_payload_nbits + p_opaque_nbits + 2*p_srcdest_nbits;
  localparam int unsigned pw = $clog2(p_num_entries);
  localparam logic [pw:0] FULL_CNT = (pw+1)'(p_num_entries);

  logic [m-1:0]  r_mem   [2][p_num_entries];
  logic [pw-1:0] r_head  [2];
  logic [pw-1:0] r_tail  [2];
  logic [pw:0]   r_cnt   [2];
  logic [7:0]    r_misroute_cnt;

  logic                       w_in_rdy;
  logic                       w_acc;
  logic                       w_misroute;
  logic [p_srcdest_nbits-1:0] w_dest;
  logic [1:0]                 w_empty;
  logic [1:0]                 w_full;
  logic [1:0]                 w_out_rdy;
  logic [1:0]                 w_enq;
  logic [1:0]                 w_byp;
  logic [1:0]                 w_wr;
  logic [1:0]                 w_deq;
  logic [1:0]                 w_out_val;
  logic [m-1:0]               w_out_msg [2];

  always_comb begin
    w_empty = '0;
    w_full  = '0;
    for (int unsigned d = 0; d < 2; d++) begin
      w_empty[d] = (r_cnt[d] == '0);
      w_full[d]  = (r_cnt[d] == FULL_CNT);
    end
  end

  // Acceptance looks only at the addressed queue's occupancy, never in_val,
  // and a full queue refuses even when it is draining this cycle.
  always_comb begin
    w_out_rdy  = {bus.out_rdy_d1, bus.out_rdy_d0};
    w_in_rdy   = bus.in_domain ? !w_full[1] : !w_full[0];
    w_acc      = bus.in_val && w_in_rdy;
    w_dest     = bus.in_msg[m-1 -: p_srcdest_nbits];
    w_misroute = w_acc && (w_dest != p_srcdest_nbits'(p_router_id));
  end

  always_comb begin
    w_enq = '0;
    w_byp = '0;
    w_wr  = '0;
    w_deq = '0;
    w_out_val = '0;
    for (int unsigned d = 0; d < 2; d++) begin
      w_out_msg[d] = r_mem[d][r_head[d]];
      w_enq[d] = w_acc && (bus.in_domain == 1'(d));
      w_deq[d] = !w_empty[d] && w_out_rdy[d];
`ifdef PLAB4_NET_TER_EJECT_BYPASS_EN
      w_byp[d] = w_enq[d] && w_empty[d] && w_out_rdy[d];
`else
      w_byp[d] = 1'b0;
`endif
      // A bypassed message is consumed directly and never written.
      w_wr[d]      = w_enq[d] && !w_byp[d];
      w_out_val[d] = !w_empty[d] || w_byp[d];
      if (w_byp[d]) w_out_msg[d] = bus.in_msg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned d = 0; d < 2; d++) begin
        r_head[d] <= '0;
        r_tail[d] <= '0;
        r_cnt[d]  <= '0;
      end
      r_misroute_cnt <= '0;
    end else begin
      for (int unsigned d = 0; d < 2; d++) begin
        if (w_wr[d])  r_tail[d] <= r_tail[d] + 1'b1;
        if (w_deq[d]) r_head[d] <= r_head[d] + 1'b1;
        case ({w_wr[d], w_deq[d]})
          2'b10:   r_cnt[d] <= r_cnt[d] + 1'b1;
          2'b01:   r_cnt[d] <= r_cnt[d] - 1'b1;
          default: r_cnt[d] <= r_cnt[d];
        endcase
      end
      if (w_misroute && (r_misroute_cnt != '1))
        r_misroute_cnt <= r_misroute_cnt + 1'b1;
    end
  end

  // Storage needs no reset: occupancy is governed solely by r_cnt.
  always_ff @(posedge clk) begin
    for (int unsigned d = 0; d < 2; d++) begin
      if (w_wr[d]) r_mem[d][r_tail[d]] <= bus.in_msg;
    end
  end

  assign bus.in_rdy       = w_in_rdy;
  assign bus.out_val_d0   = w_out_val[0];
  assign bus.out_msg_d0   = w_out_msg[0];
  assign bus.out_val_d1   = w_out_val[1];
  assign bus.out_msg_d1   = w_out_msg[1];
  assign bus.misroute_cnt = r_misroute_cnt;

endmodule
